// File: rtl/match_controller.sv
// Round/match sequencer between the action converters and the two-player board:
// start countdown, action gating, round scoring and best-of-N match decision.
module match_controller #(
    parameter int WINS_TO_MATCH = 2,
    parameter int CNTDN_TICKS   = 3,
    parameter int END_TICKS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tck,
    input  logic       strt,
    input  logic [2:0] plr_1_act_in,
    input  logic [2:0] plr_2_act_in,
    input  logic       plr_1_wn,
    input  logic       plr_2_wn,
    output logic       brd_rst,
    output logic [2:0] plr_1_act_out,
    output logic [2:0] plr_2_act_out,
    output logic [1:0] plr_1_rnd,
    output logic [1:0] plr_2_rnd,
    output logic [1:0] cntdn,
    output logic [2:0] st,
    output logic       mtch_ovr,
    output logic       mtch_wnr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNTDN    = 3'd1,
        FIGHT    = 3'd2,
        RND_END  = 3'd3,
        MTCH_END = 3'd4
    } state_t;

    localparam logic [1:0] WINS_L  = 2'(WINS_TO_MATCH);
    localparam logic [1:0] CNTDN_L = 2'(CNTDN_TICKS);
    localparam logic [1:0] END_L   = 2'(END_TICKS);

    state_t     state_r;
    logic       strt_q_r;
    logic [1:0] end_cnt_r;
    logic       strt_edge_s;
    logic [1:0] p1_next_s;
    logic [1:0] p2_next_s;

    assign strt_edge_s = strt & ~strt_q_r;
    assign p1_next_s   = plr_1_rnd + 2'd1;
    assign p2_next_s   = plr_2_rnd + 2'd1;
    assign st          = state_r;

    // Match sequencer: state, scores, countdowns and all board-facing outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            strt_q_r      <= 1'b1;
            end_cnt_r     <= 2'd0;
            brd_rst       <= 1'b0;
            plr_1_act_out <= 3'd0;
            plr_2_act_out <= 3'd0;
            plr_1_rnd     <= 2'd0;
            plr_2_rnd     <= 2'd0;
            cntdn         <= 2'd0;
            mtch_ovr      <= 1'b0;
            mtch_wnr      <= 1'b0;
        end else begin
            strt_q_r <= strt;
            case (state_r)
                IDLE: begin
                    brd_rst       <= 1'b0;
                    plr_1_act_out <= 3'd0;
                    plr_2_act_out <= 3'd0;
                    if (strt_edge_s) begin
                        state_r   <= CNTDN;
                        cntdn     <= CNTDN_L;
                        plr_1_rnd <= 2'd0;
                        plr_2_rnd <= 2'd0;
                    end
                end
                CNTDN: begin
                    brd_rst       <= 1'b0;
                    plr_1_act_out <= 3'd0;
                    plr_2_act_out <= 3'd0;
                    if (tck) begin
                        if (cntdn > 2'd1) begin
                            cntdn <= cntdn - 2'd1;
                        end else begin
                            state_r <= FIGHT;
                            cntdn   <= 2'd0;
                            brd_rst <= 1'b1;
                        end
                    end
                end
                FIGHT: begin
                    brd_rst       <= 1'b1;
                    plr_1_act_out <= plr_1_act_in;
                    plr_2_act_out <= plr_2_act_in;
                    if (plr_1_wn || plr_2_wn) begin
                        plr_1_act_out <= 3'd0;
                        plr_2_act_out <= 3'd0;
                        state_r       <= RND_END;
                        end_cnt_r     <= END_L;
                        // A draw (both flags) scores nothing but still ends the round.
                        if (plr_1_wn && !plr_2_wn) begin
                            plr_1_rnd <= p1_next_s;
                            if (p1_next_s == WINS_L) begin
                                state_r  <= MTCH_END;
                                mtch_ovr <= 1'b1;
                                mtch_wnr <= 1'b0;
                            end
                        end else if (plr_2_wn && !plr_1_wn) begin
                            plr_2_rnd <= p2_next_s;
                            if (p2_next_s == WINS_L) begin
                                state_r  <= MTCH_END;
                                mtch_ovr <= 1'b1;
                                mtch_wnr <= 1'b1;
                            end
                        end
                    end
                end
                RND_END: begin
                    brd_rst       <= 1'b1;
                    plr_1_act_out <= 3'd0;
                    plr_2_act_out <= 3'd0;
                    if (tck) begin
                        if (end_cnt_r > 2'd1) begin
                            end_cnt_r <= end_cnt_r - 2'd1;
                        end else begin
                            end_cnt_r <= 2'd0;
                            state_r   <= CNTDN;
                            brd_rst   <= 1'b0;
                            cntdn     <= CNTDN_L;
                        end
                    end
                end
                MTCH_END: begin
                    brd_rst       <= 1'b1;
                    plr_1_act_out <= 3'd0;
                    plr_2_act_out <= 3'd0;
                    mtch_ovr      <= 1'b1;
                    if (strt_edge_s) begin
                        plr_1_rnd <= 2'd0;
                        plr_2_rnd <= 2'd0;
                        mtch_ovr  <= 1'b0;
                        mtch_wnr  <= 1'b0;
                        brd_rst   <= 1'b0;
                        state_r   <= CNTDN;
                        cntdn     <= CNTDN_L;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    brd_rst       <= 1'b0;
                    plr_1_act_out <= 3'd0;
                    plr_2_act_out <= 3'd0;
                    cntdn         <= 2'd0;
                    end_cnt_r     <= 2'd0;
                    mtch_ovr      <= 1'b0;
                    mtch_wnr      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/match_controller.md
# match_controller

Round/match sequencer placed between the action converters and the two-player board. Holds the board in reset until a match is started and runs a start countdown on game ticks. During a fight it passes player actions through. It detects round wins from the board's win flags, keeps best-of-N round scores, and declares the match winner.

## Interface

Parameters:
- WINS_TO_MATCH, default 2: round wins needed to take the match; legal range 1..3.
- CNTDN_TICKS, default 3: game ticks of countdown before each round; legal range 1..3.
- END_TICKS, default 2: game ticks the finished board stays frozen before the next countdown; legal range 1..3.

Ports (one clock, `clk`; reset `rst` is synchronous, active-low):
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- tck  input  1  game-tick strobe, one clk cycle wide, synchronous to clk.
- strt  input  1  start button, level; the rising edge is used.
- plr_1_act_in  input  3  encoded player 1 action; 3'b000 = none.
- plr_2_act_in  input  3  encoded player 2 action.
- plr_1_wn  input  1  board win flag, player 1.
- plr_2_wn  input  1  board win flag, player 2.
- brd_rst  output  1  board reset, active-low; 0 holds the board at its start state.
- plr_1_act_out  output  3  gated player 1 action to board.
- plr_2_act_out  output  3  gated player 2 action to board.
- plr_1_rnd  output  2  player 1 round wins.
- plr_2_rnd  output  2  player 2 round wins.
- cntdn  output  2  countdown value for display; 0 outside CNTDN.
- st  output  3  state code.
- mtch_ovr  output  1  high in MTCH_END.
- mtch_wnr  output  1  0 = player 1 won, 1 = player 2; valid while mtch_ovr = 1.

## Operation

- States and `st` codes: IDLE = 0, CNTDN = 1, FIGHT = 2, RND_END = 3, MTCH_END = 4. Codes 5–7 are unreachable and recover to IDLE on the next edge.
- Reset (rst = 0): all outputs and internal registers go to these values:
  - st = IDLE, brd_rst = 0.
  - Action outputs, round counters, cntdn, end counter, mtch_ovr and mtch_wnr all 0.
  - strt_q = 1, so a start button held through reset is not taken as an edge.
- Start edge: strt_edge = strt & ~strt_q, where strt_q is strt registered every cycle.
- IDLE: brd_rst = 0. On strt_edge, go to CNTDN, load cntdn = CNTDN_TICKS and clear both round counters.
- CNTDN: brd_rst = 0.
  - Each tck with cntdn > 1 decrements cntdn.
  - On tck with cntdn = 1, go to FIGHT with cntdn = 0 and brd_rst = 1.
- FIGHT: brd_rst = 1. Each cycle, plr_x_act_out <= plr_x_act_in. Win flags are sampled every cycle, independent of tck:
  - Only plr_1_wn high: increment plr_1_rnd.
  - Only plr_2_wn high: increment plr_2_rnd.
  - Both high (draw): neither counter changes.
  - On any win flag: if the incremented count equals WINS_TO_MATCH, go to MTCH_END and set mtch_wnr. Otherwise go to RND_END and load the end counter with END_TICKS.
- RND_END: actions 0 and brd_rst = 1, so the board stays frozen for display.
  - Each tck decrements the end counter.
  - On tck with the end counter = 1, go to CNTDN with brd_rst = 0 and cntdn = CNTDN_TICKS.
- MTCH_END: actions 0, brd_rst = 1, mtch_ovr = 1; scores and mtch_wnr are held. On strt_edge, clear scores, mtch_ovr and mtch_wnr, set brd_rst = 0, go to CNTDN and load cntdn.
- strt_edge outside IDLE and MTCH_END is ignored.
- tck is ignored in IDLE, FIGHT and MTCH_END.
- Round counters are 2 bits, increment only, and never exceed WINS_TO_MATCH.

## Timing

- Every output is registered. A trigger sampled at edge N is reflected in outputs after edge N.
- CNTDN to FIGHT: st = FIGHT and brd_rst = 1 change on the same edge as the final tck.
- Action pass-through has 1 cycle of latency and is valid from the second cycle of FIGHT. The first FIGHT cycle outputs 000.
- A win flag sampled at edge N causes, at edge N:
  - the counter update,
  - the state change,
  - action outputs forced to 000.
- Win flags are ignored outside FIGHT, including stale flags while in RND_END.
- tck and strt_edge arriving in the same cycle: only the input relevant to the current state acts.
- rst = 0 at any point, including mid-round, returns to reset values on that edge.

## Test plan

- Reset with strt held high, then release rst → st = 0, brd_rst = 0, no transition until strt goes low and then high.
- strt edge, then 3 tck pulses (default parameters):
  - cntdn goes 3 → 2 → 1, then st = 2 and brd_rst = 1 on the third tck.
  - plr_1_act_in = 3'b101 appears on plr_1_act_out one cycle later.
- In FIGHT, pulse plr_1_wn → plr_1_rnd = 1, st = 3, actions 000. After 2 tck: st = 1, brd_rst = 0, cntdn = 3.
- Player 2 wins two rounds → plr_2_rnd = 2, st = 4, mtch_ovr = 1, mtch_wnr = 1. A new strt edge clears scores and gives st = 1.
- plr_1_wn and plr_2_wn high in the same cycle → both counters unchanged, st = 3. Separately, tck and strt pulses during FIGHT → no effect.
- rst = 0 in the middle of RND_END with plr_1_rnd = 1 → every output returns to its reset value on that edge.
